// File: rtl/fft_frame_arbiter_pkg.sv
// Shared definitions for the FFT frame arbiter slice.
// Holds the FSM state encoding, the requester-index type and the default
// values for the frame length, sample width and tag FIFO depth.
package fft_frame_arbiter_pkg;

  localparam int DEF_N         = 64;  // samples per FFT frame
  localparam int DEF_WIDTH     = 16;  // bits per real/imaginary part
  localparam int DEF_TAG_DEPTH = 4;   // frames allowed in flight

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } arb_state_t;

  // Identifies one of the two requesters (0 or 1).
  typedef logic req_idx_t;

endpackage

// File: rtl/fft_frame_arbiter_if.sv
// Signal bundle between the FFT frame arbiter and its environment.
// Contents:
//   req_valid/req_ready           per-requester sample handshake (bit 0/1)
//   req0_r/i, req1_r/i            requester sample data
//   fft_idata_en/_r/_i            samples towards the FFT pipeline
//   fft_odata_en/_r/_i            samples returning from the FFT pipeline
//   odata_en/_r/_i, odata_src     registered output stream and its owner
//   err_underrun, err_orphan      single-cycle error pulses
// Modports:
//   slave  - the arbiter itself
//   master - the environment (requesters plus FFT pipeline)
interface fft_frame_arbiter_if
  import fft_frame_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req0_r, req0_i, req1_r, req1_i;
  logic             fft_idata_en;
  logic [WIDTH-1:0] fft_idata_r, fft_idata_i;
  logic             fft_odata_en;
  logic [WIDTH-1:0] fft_odata_r, fft_odata_i;
  logic             odata_en;
  logic [WIDTH-1:0] odata_r, odata_i;
  logic             odata_src;
  logic [1:0]       err_underrun;
  logic             err_orphan;

  modport slave (
    input  req_valid, req0_r, req0_i, req1_r, req1_i,
    input  fft_odata_en, fft_odata_r, fft_odata_i,
    output req_ready, fft_idata_en, fft_idata_r, fft_idata_i,
    output odata_en, odata_r, odata_i, odata_src, err_underrun, err_orphan
  );

  modport master (
    output req_valid, req0_r, req0_i, req1_r, req1_i,
    output fft_odata_en, fft_odata_r, fft_odata_i,
    input  req_ready, fft_idata_en, fft_idata_r, fft_idata_i,
    input  odata_en, odata_r, odata_i, odata_src, err_underrun, err_orphan
  );
endinterface

// File: rtl/fft_tag_fifo.sv
// 1-bit-wide tag FIFO recording which requester owns each frame in flight.
// Ports:
//   clock, reset  clock and asynchronous active-low reset
//   push/push_tag write a tag (ignored when full)
//   pop           drop the head tag (ignored when empty)
//   head_tag      current head, valid while empty is low
//   full, empty   occupancy flags
// Push and pop in the same cycle leave the occupancy unchanged.
module fft_tag_fifo
  import fft_frame_arbiter_pkg::*;
#(
  parameter int DEPTH = DEF_TAG_DEPTH
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  logic push_tag,
  input  logic pop,
  output logic head_tag,
  output logic full,
  output logic empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic          mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push, do_pop;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // The head is read combinationally so the owner tag can be registered in
  // the same cycle as the sample it belongs to.
  assign head_tag = mem[rd_ptr_reg];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_reg] <= push_tag;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= bump(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= bump(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: rtl/fft_frame_arbiter.sv
// Arbitrates two sample requesters onto one FFT pipeline, a whole frame of
// N contiguous samples at a time, and tags returning frames with their owner.
// Ports:
//   clock  the only clock
//   reset  asynchronous active-low reset
//   bus    fft_frame_arbiter_if.slave (requester handshake, FFT in/out,
//          output stream, error pulses)
// Build option: define FFT_ARB_FIXED_PRIORITY_EN to make requester 0 win
// every tie; otherwise ties alternate round-robin.
module fft_frame_arbiter
  import fft_frame_arbiter_pkg::*;
#(
  parameter int N         = DEF_N,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int TAG_DEPTH = DEF_TAG_DEPTH
) (
  input logic              clock,
  input logic              reset,
  fft_frame_arbiter_if.slave bus
);
  localparam int CW = $clog2(N);

  arb_state_t       state_reg, state_next;
  req_idx_t         src_reg, src_next, last_reg, last_next, winner, tie_winner;
  logic [CW-1:0]    count_reg, count_next, out_count_reg, out_count_next;
  logic             push, pop, fifo_full, fifo_empty, fifo_head;
  logic             src_valid;
  logic [WIDTH-1:0] src_r, src_i;

  logic             idata_en_reg, odata_en_reg, odata_src_reg, orphan_reg;
  logic [WIDTH-1:0] idata_r_reg, idata_i_reg, odata_r_reg, odata_i_reg;
  logic [1:0]       underrun_reg;

`ifdef FFT_ARB_FIXED_PRIORITY_EN
  assign tie_winner = 1'b0;
`else
  assign tie_winner = ~last_reg;
`endif

  always_comb begin
    winner = 1'b0;
    case (bus.req_valid)
      2'b10:   winner = 1'b1;
      2'b11:   winner = tie_winner;
      default: winner = 1'b0;
    endcase
  end

  assign src_valid = bus.req_valid[src_reg];
  assign src_r     = src_reg ? bus.req1_r : bus.req0_r;
  assign src_i     = src_reg ? bus.req1_i : bus.req0_i;

  always_comb begin
    state_next    = state_reg;
    src_next      = src_reg;
    last_next     = last_reg;
    count_next    = count_reg;
    push          = 1'b0;
    bus.req_ready = 2'b00;
    case (state_reg)
      IDLE: begin
        if ((|bus.req_valid) && !fifo_full) begin
          state_next = STREAM;
          src_next   = winner;
          last_next  = winner;
          count_next = '0;
          push       = 1'b1;
        end
      end
      STREAM: begin
        // Ready follows ownership, not valid, so a gap zero-pads instead of
        // stretching the frame.
        bus.req_ready = src_reg ? 2'b10 : 2'b01;
        count_next    = count_reg + CW'(1);
        if (count_reg == CW'(N - 1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Orphan samples belong to no frame, so they neither advance the output
  // counter nor pop a tag.
  always_comb begin
    out_count_next = out_count_reg;
    if (bus.fft_odata_en && !fifo_empty) out_count_next = out_count_reg + CW'(1);
  end
  assign pop = bus.fft_odata_en && !fifo_empty && (out_count_reg == CW'(N - 1));

  fft_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_tag (winner),
    .pop      (pop),
    .head_tag (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      src_reg       <= 1'b0;
      last_reg      <= 1'b1;
      count_reg     <= '0;
      out_count_reg <= '0;
      idata_en_reg  <= 1'b0;
      idata_r_reg   <= '0;
      idata_i_reg   <= '0;
      underrun_reg  <= 2'b00;
      odata_en_reg  <= 1'b0;
      odata_r_reg   <= '0;
      odata_i_reg   <= '0;
      odata_src_reg <= 1'b0;
      orphan_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      src_reg       <= src_next;
      last_reg      <= last_next;
      count_reg     <= count_next;
      out_count_reg <= out_count_next;
      idata_en_reg  <= (state_reg == STREAM);
      idata_r_reg   <= (state_reg == STREAM && src_valid) ? src_r : '0;
      idata_i_reg   <= (state_reg == STREAM && src_valid) ? src_i : '0;
      underrun_reg  <= (state_reg == STREAM && !src_valid) ? (src_reg ? 2'b10 : 2'b01) : 2'b00;
      odata_en_reg  <= bus.fft_odata_en;
      odata_r_reg   <= bus.fft_odata_r;
      odata_i_reg   <= bus.fft_odata_i;
      odata_src_reg <= fifo_empty ? 1'b0 : fifo_head;
      orphan_reg    <= bus.fft_odata_en && fifo_empty;
    end
  end

  assign bus.fft_idata_en = idata_en_reg;
  assign bus.fft_idata_r  = idata_r_reg;
  assign bus.fft_idata_i  = idata_i_reg;
  assign bus.err_underrun = underrun_reg;
  assign bus.odata_en     = odata_en_reg;
  assign bus.odata_r      = odata_r_reg;
  assign bus.odata_i      = odata_i_reg;
  assign bus.odata_src    = odata_src_reg;
  assign bus.err_orphan   = orphan_reg;
endmodule

// File: doc/fft_frame_arbiter.md
FFT_FRAME_ARBITER -- requirements
Module: fft_frame_arbiter

Interface
REQ-001 SHALL have parameter N, default 64: FFT frame length in samples; power of two, 4 or more.
REQ-002 SHALL have parameter WIDTH, default 16: data bit length per real or imaginary part.
REQ-003 SHALL have parameter TAG_DEPTH, default 4: maximum number of frames in flight in the FFT pipeline; power of two.
REQ-004 SHALL have ports, clock and reset first:
- clock  input  1  master clock; the block's only clock.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  2  per-requester sample valid, index 0/1.
- req_ready  output  2  per-requester sample accept.
- req0_r, req0_i, req1_r, req1_i  input  WIDTH each  requester sample data.
- fft_idata_en  output  1  data enable to the FFT pipeline.
- fft_idata_r, fft_idata_i  output  WIDTH each  data to the FFT pipeline.
- fft_odata_en  input  1  data enable from the FFT pipeline.
- fft_odata_r, fft_odata_i  input  WIDTH each  data from the FFT pipeline.
- odata_en  output  1  output data enable.
- odata_r, odata_i  output  WIDTH each  output data.
- odata_src  output  1  requester that owns the current output sample.
- err_underrun  output  2  one-cycle pulse per requester: a sample was zero-padded.
- err_orphan  output  1  one-cycle pulse: output sample arrived with no tag queued.

Function
REQ-005 SHALL use a two-state FSM, IDLE and STREAM.
REQ-006 In IDLE, when at least one req_valid is high and the tag FIFO is not full, SHALL latch the winner in src, clear the sample counter, push src into the tag FIFO and enter STREAM on the next edge.
REQ-007 SHALL arbitrate round-robin: when both requesters are valid, grant the one not granted last; a lone valid requester is always granted.
REQ-008 In STREAM, req_ready[src] SHALL equal 1 combinationally; the other ready bit SHALL be 0; both bits SHALL be 0 in IDLE.
REQ-009 Each STREAM cycle SHALL register fft_idata_en=1 and the fft_idata data, which is the src requester's data when its valid is high, else zero.
REQ-010 A STREAM cycle with req_valid[src] low SHALL pulse err_underrun[src] on the next cycle; the frame length SHALL NOT change.
REQ-011 The sample counter, log2(N) bits, SHALL increment every STREAM cycle; at count N-1 the FSM SHALL return to IDLE, so every frame is exactly N contiguous enabled samples.
REQ-012 Frames SHALL be separated by at least one cycle with fft_idata_en=0, which is the IDLE cycle.
REQ-013 SHALL register fft_odata_en and fft_odata data to odata_en and odata data with 1-cycle latency; odata_src SHALL be the tag FIFO head, registered alongside.
REQ-014 An output counter SHALL count fft_odata_en cycles; at count N-1 SHALL pop the tag FIFO and wrap to 0.
REQ-015 SHALL support a simultaneous push and pop in the same cycle; the FIFO occupancy is unchanged in that case.
REQ-016 A full FIFO SHALL block new grants only; a frame already in STREAM SHALL complete.
REQ-017 When fft_odata_en is high with the FIFO empty, SHALL pulse err_orphan, drive odata_src=0 and perform no pop.

Reset
REQ-018 Reset asserted SHALL give: FSM=IDLE, all counters 0, FIFO empty, last-granted=1 (so req0 wins first), and req_ready, fft_idata_en, odata_en, err_* all 0.
REQ-019 Data outputs SHALL reset to 0.
REQ-020 Reset asserted mid-frame SHALL abort the frame and discard all tags; no resumption after reset.

Configuration
REQ-021 With macro FFT_ARB_FIXED_PRIORITY_EN defined, SHALL use fixed priority: requester 0 always wins a tie.
REQ-022 Without FFT_ARB_FIXED_PRIORITY_EN, SHALL use round-robin as in REQ-007.

Structure
REQ-023 A shared package SHALL hold the FSM state enum (IDLE, STREAM), the requester-index type and the default constants for N, WIDTH and TAG_DEPTH.
REQ-024 The tag FIFO SHALL be one sub-module, fft_tag_fifo: a 1-bit-wide FIFO, TAG_DEPTH deep, with full and empty flags.

Verification
REQ-025 N=8; req0 valid continuously -> req_ready[0] high 8 cycles, fft_idata_en 8 cycles then 0 for 1 cycle; samples 1..8 appear in order.
REQ-026 Both valid continuously -> frames granted 0,1,0,1; with FFT_ARB_FIXED_PRIORITY_EN -> 0,0,0,0.
REQ-027 req0 valid dropped on sample 3 of a frame -> fft_idata carries 0 for that sample, err_underrun=2'b01 for one cycle, frame still 8 samples.
REQ-028 Loopback FFT model with 3 frames latency, TAG_DEPTH=2 -> third grant stalls until the first output frame completes; odata_src matches grant order.
REQ-029 fft_odata_en pulsed with no frame granted -> err_orphan=1 for one cycle, odata_src=0.
REQ-030 reset asserted at sample 4 of a frame -> all outputs 0 next cycle; after release, req0 is granted first.
